// File: rtl/riscv_axi_mem_arbiter.sv
// riscv_axi_mem_arbiter
//   2:1 AXI4 arbiter in front of the single DRAM master port. Port s0 is the
//   core memory port, s1 the host/debug loader path. Reads and writes
//   arbitrate independently and each direction carries one burst at a time.
//   The downstream ID is {port, upstream ID}. Responses are steered by the
//   registered grant, not by the returned ID.
//
// Ports
//   aclk, areset        single clock, asynchronous active-high reset
//   sN_ar*/sN_r*        upstream read address / read data (N = 0, 1)
//   sN_aw*/sN_w*/sN_b*  upstream write address / data / response
//   m_*                 downstream master, ID width ID_W+1
//
// Configuration
//   RISCV_AXI_ARB_FIXED_PRIO_EN  s0 always wins simultaneous requests and
//                                the round-robin pointers are removed.
//                                Default: round-robin per direction.
module riscv_axi_mem_arbiter #(
  parameter int ID_W   = 5,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              aclk,
  input  logic              areset,
  // s0
  input  logic [ID_W-1:0]   s0_arid,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [7:0]        s0_arlen,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [ID_W-1:0]   s0_rid,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  input  logic [ID_W-1:0]   s0_awid,
  input  logic [ADDR_W-1:0] s0_awaddr,
  input  logic [7:0]        s0_awlen,
  input  logic              s0_awvalid,
  output logic              s0_awready,
  input  logic [DATA_W-1:0] s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  input  logic              s0_wlast,
  input  logic              s0_wvalid,
  output logic              s0_wready,
  output logic [ID_W-1:0]   s0_bid,
  output logic [1:0]        s0_bresp,
  output logic              s0_bvalid,
  input  logic              s0_bready,
  // s1
  input  logic [ID_W-1:0]   s1_arid,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [7:0]        s1_arlen,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [ID_W-1:0]   s1_rid,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  input  logic [ID_W-1:0]   s1_awid,
  input  logic [ADDR_W-1:0] s1_awaddr,
  input  logic [7:0]        s1_awlen,
  input  logic              s1_awvalid,
  output logic              s1_awready,
  input  logic [DATA_W-1:0] s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  input  logic              s1_wlast,
  input  logic              s1_wvalid,
  output logic              s1_wready,
  output logic [ID_W-1:0]   s1_bid,
  output logic [1:0]        s1_bresp,
  output logic              s1_bvalid,
  input  logic              s1_bready,
  // downstream master
  output logic [ID_W:0]     m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [ID_W:0]     m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [ID_W:0]     m_awid,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [7:0]        m_awlen,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic              m_wlast,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [ID_W:0]     m_bid,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_st_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_st_t;

  rd_st_t rd_st_q, rd_st_d;
  wr_st_t wr_st_q, wr_st_d;
  logic   rd_g_q, rd_g_d, wr_g_q, wr_g_d;
  logic   aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic   rd_pick, wr_pick, rd_done, wr_done;

  // Granted-port views of the upstream signals
  logic sg_arvalid, sg_rready, sg_awvalid, sg_wvalid, sg_wlast, sg_bready;
  assign sg_arvalid = rd_g_q ? s1_arvalid : s0_arvalid;
  assign sg_rready  = rd_g_q ? s1_rready  : s0_rready;
  assign sg_awvalid = wr_g_q ? s1_awvalid : s0_awvalid;
  assign sg_wvalid  = wr_g_q ? s1_wvalid  : s0_wvalid;
  assign sg_wlast   = wr_g_q ? s1_wlast   : s0_wlast;
  assign sg_bready  = wr_g_q ? s1_bready  : s0_bready;

  // Payload muxes / broadcasts; only the valids are steered
  assign m_arid   = {rd_g_q, rd_g_q ? s1_arid : s0_arid};
  assign m_araddr = rd_g_q ? s1_araddr : s0_araddr;
  assign m_arlen  = rd_g_q ? s1_arlen  : s0_arlen;
  assign m_awid   = {wr_g_q, wr_g_q ? s1_awid : s0_awid};
  assign m_awaddr = wr_g_q ? s1_awaddr : s0_awaddr;
  assign m_awlen  = wr_g_q ? s1_awlen  : s0_awlen;
  assign m_wdata  = wr_g_q ? s1_wdata  : s0_wdata;
  assign m_wstrb  = wr_g_q ? s1_wstrb  : s0_wstrb;
  assign m_wlast  = sg_wlast;

  assign s0_rid   = m_rid[ID_W-1:0];
  assign s1_rid   = m_rid[ID_W-1:0];
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;
  assign s0_rresp = m_rresp;
  assign s1_rresp = m_rresp;
  assign s0_rlast = m_rlast;
  assign s1_rlast = m_rlast;
  assign s0_bid   = m_bid[ID_W-1:0];
  assign s1_bid   = m_bid[ID_W-1:0];
  assign s0_bresp = m_bresp;
  assign s1_bresp = m_bresp;

  // Returned ID MSB duplicates the registered grant, so it is not consulted
  logic unused_id_msb;
  assign unused_id_msb = m_rid[ID_W] ^ m_bid[ID_W];

`ifdef RISCV_AXI_ARB_FIXED_PRIO_EN
  assign rd_pick = ~s0_arvalid;
  assign wr_pick = ~s0_awvalid;
  logic unused_done;
  assign unused_done = rd_done ^ wr_done;
`else
  // Pointer names the port preferred on a tie; it points away from the last winner
  logic rd_ptr_q, wr_ptr_q;
  assign rd_pick = (s0_arvalid && s1_arvalid) ? rd_ptr_q : s1_arvalid;
  assign wr_pick = (s0_awvalid && s1_awvalid) ? wr_ptr_q : s1_awvalid;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (rd_done) rd_ptr_q <= ~rd_g_q;
      if (wr_done) wr_ptr_q <= ~wr_g_q;
    end
  end
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_st_q   <= R_IDLE;
      wr_st_q   <= W_IDLE;
      rd_g_q    <= 1'b0;
      wr_g_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      rd_st_q   <= rd_st_d;
      wr_st_q   <= wr_st_d;
      rd_g_q    <= rd_g_d;
      wr_g_q    <= wr_g_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Read direction
  always_comb begin
    rd_st_d    = rd_st_q;
    rd_g_d     = rd_g_q;
    rd_done    = 1'b0;
    m_arvalid  = 1'b0;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    m_rready   = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    case (rd_st_q)
      R_IDLE: if (s0_arvalid || s1_arvalid) begin
        rd_g_d  = rd_pick;
        rd_st_d = R_ADDR;
      end
      R_ADDR: begin
        m_arvalid  = sg_arvalid;
        s0_arready = ~rd_g_q & m_arready;
        s1_arready =  rd_g_q & m_arready;
        if (sg_arvalid && m_arready) rd_st_d = R_DATA;
      end
      R_DATA: begin
        m_rready  = sg_rready;
        s0_rvalid = ~rd_g_q & m_rvalid;
        s1_rvalid =  rd_g_q & m_rvalid;
        if (m_rvalid && sg_rready && m_rlast) begin
          rd_done = 1'b1;
          rd_st_d = R_IDLE;
        end
      end
      default: rd_st_d = R_IDLE;
    endcase
  end

  // Write direction: AW and W run in parallel; the done flags let either finish first
  always_comb begin
    wr_st_d    = wr_st_q;
    wr_g_d     = wr_g_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    wr_done    = 1'b0;
    m_awvalid  = 1'b0;
    s0_awready = 1'b0;
    s1_awready = 1'b0;
    m_wvalid   = 1'b0;
    s0_wready  = 1'b0;
    s1_wready  = 1'b0;
    m_bready   = 1'b0;
    s0_bvalid  = 1'b0;
    s1_bvalid  = 1'b0;
    case (wr_st_q)
      W_IDLE: if (s0_awvalid || s1_awvalid) begin
        wr_g_d  = wr_pick;
        wr_st_d = W_ADDR;
      end
      W_ADDR: begin
        m_awvalid  = sg_awvalid & ~aw_done_q;
        s0_awready = ~wr_g_q & m_awready & ~aw_done_q;
        s1_awready =  wr_g_q & m_awready & ~aw_done_q;
        m_wvalid   = sg_wvalid & ~w_done_q;
        s0_wready  = ~wr_g_q & m_wready & ~w_done_q;
        s1_wready  =  wr_g_q & m_wready & ~w_done_q;
        aw_done_d  = aw_done_q | (m_awvalid & m_awready);
        w_done_d   = w_done_q  | (m_wvalid & m_wready & sg_wlast);
        if (aw_done_d && w_done_d) wr_st_d = W_RESP;
      end
      W_RESP: begin
        m_bready  = sg_bready;
        s0_bvalid = ~wr_g_q & m_bvalid;
        s1_bvalid =  wr_g_q & m_bvalid;
        if (m_bvalid && sg_bready) begin
          wr_done   = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wr_st_d   = W_IDLE;
        end
      end
      default: wr_st_d = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_riscv_axi_mem_arbiter.sv
// Directed bench for riscv_axi_mem_arbiter. The bench plays both upstream
// masters and the downstream slave; inputs change 1ns after the rising edge
// and outputs are checked 2ns after it.
module tb_riscv_axi_mem_arbiter;
  localparam int ID_W = 5, ADDR_W = 32, DATA_W = 64;

  logic aclk, areset;
  logic [ID_W-1:0] s0_arid, s1_arid, s0_awid, s1_awid;
  logic [ADDR_W-1:0] s0_araddr, s1_araddr, s0_awaddr, s1_awaddr;
  logic [7:0] s0_arlen, s1_arlen, s0_awlen, s1_awlen;
  logic s0_arvalid, s1_arvalid, s0_arready, s1_arready;
  logic [ID_W-1:0] s0_rid, s1_rid, s0_bid, s1_bid;
  logic [DATA_W-1:0] s0_rdata, s1_rdata, s0_wdata, s1_wdata;
  logic [1:0] s0_rresp, s1_rresp, s0_bresp, s1_bresp;
  logic s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_rready, s1_rready;
  logic s0_awvalid, s1_awvalid, s0_awready, s1_awready;
  logic [DATA_W/8-1:0] s0_wstrb, s1_wstrb, m_wstrb;
  logic s0_wlast, s1_wlast, s0_wvalid, s1_wvalid, s0_wready, s1_wready;
  logic s0_bvalid, s1_bvalid, s0_bready, s1_bready;
  logic [ID_W:0] m_arid, m_rid, m_awid, m_bid;
  logic [ADDR_W-1:0] m_araddr, m_awaddr;
  logic [7:0] m_arlen, m_awlen;
  logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic [DATA_W-1:0] m_rdata, m_wdata;
  logic [1:0] m_rresp, m_bresp;
  logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

  int n_chk = 0, n_pass = 0;

  riscv_axi_mem_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .aclk(aclk), .areset(areset),
    .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s0_awid(s0_awid), .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_bid(s0_bid), .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .s1_awid(s1_awid), .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_bid(s1_bid), .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    m_rvalid = 1'b1; m_bvalid = 1'b1; s0_arvalid = 1'b1; s1_awvalid = 1'b1;
    repeat (2) @(posedge aclk);
    #2;
    n_chk++;
    if ({s0_arready, s1_arready, s0_rvalid, s1_rvalid, s0_awready, s1_awready, s0_wready, s1_wready,
         s0_bvalid, s1_bvalid, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready} !== 15'd0)
      $display("FAIL reset_outputs: got some valid/ready high, want all 0 (m_arvalid=%b m_rready=%b)", m_arvalid, m_rready);
    else n_pass++;
    s0_arvalid = 1'b0; s1_awvalid = 1'b0;
    tick();
    areset = 1'b0;
    #1;
    // downstream response while idle must stall, not be consumed
    n_chk++;
    if ({m_rready, m_bready, s0_rvalid, s1_rvalid, s0_bvalid, s1_bvalid} !== 6'd0)
      $display("FAIL idle_stall: m_rready=%b m_bready=%b, want 0", m_rready, m_bready);
    else n_pass++;
    m_rvalid = 1'b0; m_bvalid = 1'b0;
  endtask

  task automatic test_read_burst();
    s0_arid = 5'd5; s0_araddr = 32'h1000; s0_arlen = 8'd3; s0_arvalid = 1'b1;
    m_arready = 1'b1; s0_rready = 1'b1; s1_rready = 1'b1;
    #1;
    n_chk++;
    if (m_arvalid !== 1'b0) $display("FAIL grant_latency: m_arvalid=%b want 0", m_arvalid);
    else n_pass++;
    tick(); #1;
    n_chk++;
    if (m_arvalid !== 1'b1 || m_arid !== 6'h05 || m_araddr !== 32'h1000 || m_arlen !== 8'd3 || s0_arready !== 1'b1 || s1_arready !== 1'b0)
      $display("FAIL ar_fwd: valid=%b id=%h addr=%h len=%0d s0rdy=%b, want 1 05 1000 3 1", m_arvalid, m_arid, m_araddr, m_arlen, s0_arready);
    else n_pass++;
    tick();
    s0_arvalid = 1'b0;
    m_rid = 6'h05; m_rresp = 2'b00;
    for (int i = 0; i < 4; i++) begin
      m_rvalid = 1'b1; m_rdata = 64'h100 + 64'(i); m_rlast = (i == 3);
      #1;
      n_chk++;
      if (s0_rvalid !== 1'b1 || s0_rdata !== 64'h100 + 64'(i) || s0_rlast !== (i == 3) || s0_rid !== 5'd5 || s1_rvalid !== 1'b0 || m_rready !== 1'b1)
        $display("FAIL r_beat%0d: s0v=%b data=%h last=%b id=%h s1v=%b, want 1 %h %b 05 0", i, s0_rvalid, s0_rdata, s0_rlast, s0_rid, s1_rvalid, 64'h100 + 64'(i), (i == 3));
      else n_pass++;
      tick();
    end
    m_rlast = 1'b0;
    #1;
    n_chk++;
    if (m_rready !== 1'b0 || s0_rvalid !== 1'b0)
      $display("FAIL r_after_last: m_rready=%b s0_rvalid=%b, want 0 0", m_rready, s0_rvalid);
    else n_pass++;
    m_rvalid = 1'b0;
  endtask

  task automatic test_arbitration();
    logic [5:0] exp_id [5];
    logic [5:0] gid;
    int cnt;
`ifdef RISCV_AXI_ARB_FIXED_PRIO_EN
    exp_id = '{6'h01, 6'h22, 6'h01, 6'h01, 6'h22};
`else
    exp_id = '{6'h01, 6'h22, 6'h01, 6'h22, 6'h01};
`endif
    areset = 1'b1; tick(); areset = 1'b0;
    s0_arid = 5'd1; s1_arid = 5'd2; s0_arlen = 8'd0; s1_arlen = 8'd0;
    s0_araddr = 32'h40; s1_araddr = 32'h80;
    m_arready = 1'b1; s0_rready = 1'b1; s1_rready = 1'b1;
    // k=0,1: simultaneous pair; k=2: s0 alone; k=3,4: simultaneous pair
    for (int k = 0; k < 5; k++) begin
      if (k == 0 || k == 3) begin s0_arvalid = 1'b1; s1_arvalid = 1'b1; end
      if (k == 2) s0_arvalid = 1'b1;
      cnt = 0;
      #1;
      while (m_arvalid !== 1'b1 && cnt < 10) begin tick(); #1; cnt++; end
      n_chk++;
      if (m_arvalid !== 1'b1 || m_arid !== exp_id[k])
        $display("FAIL arb_grant%0d: m_arvalid=%b m_arid=%h, want 1 %h", k, m_arvalid, m_arid, exp_id[k]);
      else n_pass++;
      gid = m_arid;
      tick();
      if (gid[5]) s1_arvalid = 1'b0; else s0_arvalid = 1'b0;
      m_rvalid = 1'b1; m_rid = gid; m_rlast = 1'b1; m_rdata = 64'(k);
      #1;
      n_chk++;
      if ({s1_rvalid, s0_rvalid} !== (gid[5] ? 2'b10 : 2'b01))
        $display("FAIL arb_route%0d: {s1,s0}_rvalid=%b, want %b", k, {s1_rvalid, s0_rvalid}, (gid[5] ? 2'b10 : 2'b01));
      else n_pass++;
      tick();
      m_rvalid = 1'b0; m_rlast = 1'b0;
    end
  endtask

  task automatic test_write_early_w();
    s1_awid = 5'd3; s1_awaddr = 32'h2000; s1_awlen = 8'd1; s1_awvalid = 1'b1;
    s1_wvalid = 1'b1; s1_wdata = 64'h1111; s1_wstrb = 8'hFF; s1_wlast = 1'b0;
    s0_wvalid = 1'b1; s0_wdata = 64'hDEAD; s0_wstrb = 8'h0F; s0_wlast = 1'b1;
    m_awready = 1'b0; m_wready = 1'b1; s0_bready = 1'b1; s1_bready = 1'b1;
    #1;
    n_chk++;
    if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0)
      $display("FAIL w_idle: m_awvalid=%b m_wvalid=%b, want 0 0", m_awvalid, m_wvalid);
    else n_pass++;
    tick(); #1;
    n_chk++;
    if (m_awvalid !== 1'b1 || m_awid !== 6'h23 || m_awaddr !== 32'h2000 || m_wvalid !== 1'b1 || m_wdata !== 64'h1111 ||
        m_wstrb !== 8'hFF || s1_wready !== 1'b1 || s0_wready !== 1'b0 || s1_awready !== 1'b0)
      $display("FAIL aw_w_fwd: awv=%b awid=%h wv=%b wdata=%h s1wr=%b s0wr=%b, want 1 23 1 1111 1 0", m_awvalid, m_awid, m_wvalid, m_wdata, s1_wready, s0_wready);
    else n_pass++;
    tick();
    s1_wdata = 64'h2222; s1_wlast = 1'b1;
    #1;
    n_chk++;
    if (m_wdata !== 64'h2222 || m_wlast !== 1'b1) $display("FAIL w_beat1: data=%h last=%b, want 2222 1", m_wdata, m_wlast);
    else n_pass++;
    tick();
    s1_wvalid = 1'b0; s1_wlast = 1'b0;
    #1;
    n_chk++;
    if (m_wvalid !== 1'b0 || m_awvalid !== 1'b1 || s1_bvalid !== 1'b0)
      $display("FAIL w_done_wait_aw: m_wvalid=%b m_awvalid=%b, want 0 1", m_wvalid, m_awvalid);
    else n_pass++;
    repeat (2) tick();
    m_awready = 1'b1;
    #1;
    n_chk++;
    if (s1_awready !== 1'b1 || s0_awready !== 1'b0) $display("FAIL aw_late_ready: s1_awready=%b s0_awready=%b, want 1 0", s1_awready, s0_awready);
    else n_pass++;
    tick();
    s1_awvalid = 1'b0; m_awready = 1'b0; s0_wvalid = 1'b0;
    m_bvalid = 1'b1; m_bid = 6'h23; m_bresp = 2'b10;
    #1;
    n_chk++;
    if (s1_bvalid !== 1'b1 || s0_bvalid !== 1'b0 || s1_bid !== 5'd3 || s1_bresp !== 2'b10 || m_bready !== 1'b1)
      $display("FAIL b_route: s1bv=%b s0bv=%b bid=%h bresp=%b mbr=%b, want 1 0 03 10 1", s1_bvalid, s0_bvalid, s1_bid, s1_bresp, m_bready);
    else n_pass++;
    tick();
    #1;
    n_chk++;
    if (s1_bvalid !== 1'b0 || m_bready !== 1'b0) $display("FAIL b_after: s1_bvalid=%b m_bready=%b, want 0 0", s1_bvalid, m_bready);
    else n_pass++;
    m_bvalid = 1'b0;
  endtask

  task automatic test_concurrent();
    s0_arid = 5'd6; s0_araddr = 32'h3000; s0_arlen = 8'd1; s0_arvalid = 1'b1;
    s1_awid = 5'd9; s1_awaddr = 32'h4000; s1_awlen = 8'd0; s1_awvalid = 1'b1;
    s1_wvalid = 1'b1; s1_wdata = 64'hCAFE; s1_wlast = 1'b1;
    m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1; s0_rready = 1'b1; s1_bready = 1'b1;
    tick(); #1;
    n_chk++;
    if (m_arvalid !== 1'b1 || m_arid !== 6'h06 || m_awvalid !== 1'b1 || m_awid !== 6'h29 || m_wvalid !== 1'b1)
      $display("FAIL conc_addr: arv=%b arid=%h awv=%b awid=%h wv=%b, want 1 06 1 29 1", m_arvalid, m_arid, m_awvalid, m_awid, m_wvalid);
    else n_pass++;
    tick();
    s0_arvalid = 1'b0; s1_awvalid = 1'b0; s1_wvalid = 1'b0; s1_wlast = 1'b0;
    m_rvalid = 1'b1; m_rid = 6'h06; m_rdata = 64'hBEEF; m_rlast = 1'b0;
    m_bvalid = 1'b1; m_bid = 6'h29; m_bresp = 2'b01;
    #1;
    n_chk++;
    if ({s1_rvalid, s0_rvalid} !== 2'b01 || {s1_bvalid, s0_bvalid} !== 2'b10 || s1_bid !== 5'd9 || s1_bresp !== 2'b01)
      $display("FAIL conc_route: rv=%b bv=%b bid=%h bresp=%b, want 01 10 09 01", {s1_rvalid, s0_rvalid}, {s1_bvalid, s0_bvalid}, s1_bid, s1_bresp);
    else n_pass++;
    tick();
    m_rlast = 1'b1;
    #1;
    n_chk++;
    if (s0_rvalid !== 1'b1 || {s1_bvalid, s0_bvalid} !== 2'b00 || m_bready !== 1'b0)
      $display("FAIL conc_tail: s0_rvalid=%b bv=%b m_bready=%b, want 1 00 0", s0_rvalid, {s1_bvalid, s0_bvalid}, m_bready);
    else n_pass++;
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0; m_bvalid = 1'b0;
  endtask

  task automatic test_backpressure();
    int i, cnt;
    s0_arid = 5'd4; s0_araddr = 32'h5000; s0_arlen = 8'd7; s0_arvalid = 1'b1; m_arready = 1'b1;
    tick(); tick();
    s0_arvalid = 1'b0;
    i = 0; cnt = 0;
    while (i < 8 && cnt < 100) begin
      m_rvalid = 1'b1; m_rid = 6'h04; m_rdata = 64'hA5A5_0000_0000_0000 | 64'(i); m_rlast = (i == 7);
      s0_rready = 1'($urandom_range(0, 1));
      #1;
      n_chk++;
      if (m_rready !== s0_rready) $display("FAIL bp_rready: m_rready=%b want %b", m_rready, s0_rready);
      else n_pass++;
      if (s0_rready) begin
        n_chk++;
        if (s0_rvalid !== 1'b1 || s0_rdata !== (64'hA5A5_0000_0000_0000 | 64'(i)) || s0_rlast !== (i == 7))
          $display("FAIL bp_rbeat%0d: v=%b data=%h last=%b", i, s0_rvalid, s0_rdata, s0_rlast);
        else n_pass++;
        i++;
      end
      tick(); cnt++;
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; s0_rready = 1'b1;
    n_chk++;
    if (i != 8) $display("FAIL bp_read_timeout: beats=%0d want 8", i);
    else n_pass++;

    s0_awid = 5'd4; s0_awaddr = 32'h6000; s0_awlen = 8'd7; s0_awvalid = 1'b1; m_awready = 1'b1;
    s0_wvalid = 1'b1; s0_wstrb = 8'hFF; s0_bready = 1'b1;
    tick();
    i = 0; cnt = 0;
    while (i < 8 && cnt < 100) begin
      s0_wdata = 64'h5A5A_0000_0000_0000 | 64'(i); s0_wlast = (i == 7);
      m_wready = 1'($urandom_range(0, 1));
      #1;
      n_chk++;
      if (m_wvalid !== 1'b1 || m_wdata !== (64'h5A5A_0000_0000_0000 | 64'(i)) || m_wlast !== (i == 7) || s0_wready !== m_wready)
        $display("FAIL bp_wbeat%0d: v=%b data=%h last=%b wready=%b", i, m_wvalid, m_wdata, m_wlast, s0_wready);
      else n_pass++;
      if (m_wready) i++;
      tick(); cnt++;
      s0_awvalid = 1'b0;
    end
    s0_wvalid = 1'b0; s0_wlast = 1'b0; m_wready = 1'b1;
    m_bvalid = 1'b1; m_bid = 6'h04; m_bresp = 2'b00;
    #1;
    n_chk++;
    if (i != 8 || s0_bvalid !== 1'b1) $display("FAIL bp_write_end: beats=%0d s0_bvalid=%b, want 8 1", i, s0_bvalid);
    else n_pass++;
    tick();
    m_bvalid = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    s0_arid = 5'd1; s0_araddr = 32'h7000; s0_arlen = 8'd3; s0_arvalid = 1'b1;
    m_arready = 1'b1; s0_rready = 1'b1;
    tick(); tick();
    s0_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rid = 6'h01; m_rdata = 64'd1; m_rlast = 1'b0;
    tick();
    m_rdata = 64'd2;
    #1;
    n_chk++;
    if (s0_rvalid !== 1'b1) $display("FAIL rst_pre_beat2: s0_rvalid=%b want 1", s0_rvalid);
    else n_pass++;
    areset = 1'b1;
    #1;
    n_chk++;
    if (s0_rvalid !== 1'b0 || m_rready !== 1'b0 || m_arvalid !== 1'b0)
      $display("FAIL rst_async: s0_rvalid=%b m_rready=%b m_arvalid=%b, want 0 0 0", s0_rvalid, m_rready, m_arvalid);
    else n_pass++;
    m_rvalid = 1'b0;
    tick();
    areset = 1'b0;
    s1_arid = 5'd7; s1_araddr = 32'h8000; s1_arlen = 8'd0; s1_arvalid = 1'b1; s1_rready = 1'b1;
    tick(); #1;
    n_chk++;
    if (m_arvalid !== 1'b1 || m_arid !== 6'h27 || s1_arready !== 1'b1 || s0_arready !== 1'b0)
      $display("FAIL rst_regrant: arv=%b arid=%h s1ar=%b, want 1 27 1", m_arvalid, m_arid, s1_arready);
    else n_pass++;
    tick();
    s1_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rid = 6'h27; m_rlast = 1'b1; m_rdata = 64'h77;
    #1;
    n_chk++;
    if (s1_rvalid !== 1'b1 || s0_rvalid !== 1'b0 || s1_rdata !== 64'h77)
      $display("FAIL rst_resp: s1v=%b s0v=%b data=%h, want 1 0 77", s1_rvalid, s0_rvalid, s1_rdata);
    else n_pass++;
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    s0_arid = '0; s0_araddr = '0; s0_arlen = '0; s0_arvalid = 1'b0; s0_rready = 1'b0;
    s0_awid = '0; s0_awaddr = '0; s0_awlen = '0; s0_awvalid = 1'b0;
    s0_wdata = '0; s0_wstrb = '0; s0_wlast = 1'b0; s0_wvalid = 1'b0; s0_bready = 1'b0;
    s1_arid = '0; s1_araddr = '0; s1_arlen = '0; s1_arvalid = 1'b0; s1_rready = 1'b0;
    s1_awid = '0; s1_awaddr = '0; s1_awlen = '0; s1_awvalid = 1'b0;
    s1_wdata = '0; s1_wstrb = '0; s1_wlast = 1'b0; s1_wvalid = 1'b0; s1_bready = 1'b0;
    m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
    test_reset();
    test_read_burst();
    test_arbitration();
    test_write_early_w();
    test_concurrent();
    test_backpressure();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
